// File: rtl/pc_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pc_gen: fetch PC generator with redirect priority and return stack    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module pc_gen #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h8000_0000,
   parameter int                INST_BYTES = 4,
   parameter int                RAS_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush_valid,
   input  logic [ADDR_W-1:0] flush_addr,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_addr,
   input  logic              jmp_valid,
   input  logic [ADDR_W-1:0] jmp_addr,
   input  logic              jr_valid,
   input  logic [ADDR_W-1:0] jr_addr,
   input  logic              call,
   input  logic              ret,
   output logic [ADDR_W-1:0] inst_address,
   output logic [ADDR_W-1:0] next_instaddress,
   output logic              ce,
   output logic              misalign,
   output logic              ras_empty,
   output logic              ras_full
);
   localparam int                c_PTR_W      = $clog2(RAS_DEPTH);
   localparam int                c_CNT_W      = $clog2(RAS_DEPTH + 1);
   localparam logic [ADDR_W-1:0] c_INC        = ADDR_W'(INST_BYTES);
   localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_FULL  = c_CNT_W'(RAS_DEPTH);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               ce_q, ce_d;
   logic               misalign_q, misalign_d;
   logic [c_PTR_W-1:0] ptr_q, ptr_d;
   logic [c_CNT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0]  ras_q [RAS_DEPTH];

   logic               ras_we;
   logic [c_PTR_W-1:0] ras_wptr;
   logic [ADDR_W-1:0]  ras_top;
   logic [ADDR_W-1:0]  target;
   logic               redirect;
   logic               push;
   logic               pop;

   assign next_instaddress = pc_q + c_INC;
   assign inst_address     = pc_q;
   assign ce               = ce_q;
   assign misalign         = misalign_q;
   assign ras_empty        = (cnt_q == '0);
   assign ras_full         = (cnt_q == c_CNT_FULL);
   assign ras_top          = ras_q[ptr_q];

   always_comb begin
      pc_d       = pc_q;
      ce_d       = 1'b1;
      misalign_d = 1'b0;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      ras_we     = 1'b0;
      ras_wptr   = ptr_q;
      target     = '0;
      redirect   = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;

      if (ce_q) begin
         if (flush_valid) begin
            target   = flush_addr;
            redirect = 1'b1;
            cnt_d    = '0;
         end else if (stall) begin
            pc_d = pc_q;
         end else if (jr_valid) begin
            // Return prediction falls back to the register target when the stack is empty
            pop      = ret && !ras_empty;
            push     = call;
            target   = pop ? ras_top : jr_addr;
            redirect = 1'b1;
         end else if (br_taken) begin
            target   = br_addr;
            redirect = 1'b1;
         end else if (jmp_valid) begin
            push     = call;
            target   = jmp_addr;
            redirect = 1'b1;
         end else begin
            pc_d = next_instaddress;
         end

         if (redirect) begin
            pc_d       = target & ~c_ALIGN_MASK;
            misalign_d = |(target & c_ALIGN_MASK);
         end

         // Pop-then-push collapses to rewriting the top in place
         if (pop && push) begin
            ras_we = 1'b1;
         end else if (pop) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
         end else if (push) begin
            ptr_d    = ptr_q + 1'b1;
            ras_wptr = ptr_q + 1'b1;
            ras_we   = 1'b1;
            if (!ras_full) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_ADDR;
         ce_q       <= 1'b0;
         misalign_q <= 1'b0;
         ptr_q      <= '0;
         cnt_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         ce_q       <= ce_d;
         misalign_q <= misalign_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Entry storage carries no reset; entries are only read once written
   always_ff @(posedge clk) begin
      if (ras_we) begin
         ras_q[ras_wptr] <= next_instaddress;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pc_gen: directed self-checking bench for pc_gen                     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_pc_gen;
   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush_valid, br_taken, jmp_valid, jr_valid, call, ret;
   logic [31:0] flush_addr, br_addr, jmp_addr, jr_addr;
   logic [31:0] inst_address, next_instaddress;
   logic        ce, misalign, ras_empty, ras_full;

   int tests_run    = 0;
   int tests_failed = 0;

   pc_gen #(
      .ADDR_W    (32),
      .RESET_ADDR(32'h8000_0000),
      .INST_BYTES(4),
      .RAS_DEPTH (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .flush_valid     (flush_valid),
      .flush_addr      (flush_addr),
      .br_taken        (br_taken),
      .br_addr         (br_addr),
      .jmp_valid       (jmp_valid),
      .jmp_addr        (jmp_addr),
      .jr_valid        (jr_valid),
      .jr_addr         (jr_addr),
      .call            (call),
      .ret             (ret),
      .inst_address    (inst_address),
      .next_instaddress(next_instaddress),
      .ce              (ce),
      .misalign        (misalign),
      .ras_empty       (ras_empty),
      .ras_full        (ras_full)
   );

   always #5 clk = ~clk;

   task automatic idle();
      stall = 0; flush_valid = 0; br_taken = 0; jmp_valid = 0; jr_valid = 0;
      call = 0; ret = 0;
      flush_addr = '0; br_addr = '0; jmp_addr = '0; jr_addr = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_flush(input logic [31:0] a);
      idle(); flush_valid = 1; flush_addr = a;
      tick(); idle();
   endtask

   task automatic test_reset();
      idle(); rst = 1;
      repeat (2) @(negedge clk);
      tests_run++; if (inst_address !== 32'h8000_0000) begin tests_failed++; $display("FAIL reset_pc: got %h want 80000000", inst_address); end
      tests_run++; if (ce !== 1'b0) begin tests_failed++; $display("FAIL reset_ce: got %b want 0", ce); end
      tests_run++; if (misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign: got %b want 0", misalign); end
      tests_run++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin tests_failed++; $display("FAIL reset_ras: got empty=%b full=%b want 1 0", ras_empty, ras_full); end
      tests_run++; if (next_instaddress !== 32'h8000_0004) begin tests_failed++; $display("FAIL reset_next: got %h want 80000004", next_instaddress); end
      // Redirect present on the first edge must be ignored while ce is low
      rst = 0; br_taken = 1; br_addr = 32'h8000_0400;
      tick(); idle();
      tests_run++; if (ce !== 1'b1 || inst_address !== 32'h8000_0000) begin tests_failed++; $display("FAIL release_first: got ce=%b pc=%h want 1 80000000", ce, inst_address); end
      tick();
      tests_run++; if (inst_address !== 32'h8000_0004) begin tests_failed++; $display("FAIL release_seq1: got %h want 80000004", inst_address); end
      tick();
      tests_run++; if (inst_address !== 32'h8000_0008) begin tests_failed++; $display("FAIL release_seq2: got %h want 80000008", inst_address); end
   endtask

   task automatic test_priority();
      jmp_valid = 1; jmp_addr = 32'h8000_0100; call = 1;
      tick(); idle();
      tests_run++; if (inst_address !== 32'h8000_0100 || ras_empty !== 1'b0) begin tests_failed++; $display("FAIL prio_setup: got pc=%h empty=%b want 80000100 0", inst_address, ras_empty); end
      flush_valid = 1; flush_addr = 32'h8000_1000; stall = 1;
      jr_valid = 1; jr_addr = 32'h8000_2000; br_taken = 1; br_addr = 32'h8000_3000;
      jmp_valid = 1; jmp_addr = 32'h8000_4000; call = 1; ret = 1;
      tick();
      tests_run++; if (inst_address !== 32'h8000_1000 || ras_empty !== 1'b1) begin tests_failed++; $display("FAIL prio_flush: got pc=%h empty=%b want 80001000 1", inst_address, ras_empty); end
      flush_valid = 0;
      tick();
      tests_run++; if (inst_address !== 32'h8000_1000 || ras_empty !== 1'b1) begin tests_failed++; $display("FAIL prio_stall: got pc=%h empty=%b want 80001000 1", inst_address, ras_empty); end
      stall = 0;
      tick();
      tests_run++; if (inst_address !== 32'h8000_2000 || ras_empty !== 1'b0) begin tests_failed++; $display("FAIL prio_jr: got pc=%h empty=%b want 80002000 0", inst_address, ras_empty); end
      jr_valid = 0;
      tick(); idle();
      tests_run++; if (inst_address !== 32'h8000_3000) begin tests_failed++; $display("FAIL prio_br: got %h want 80003000", inst_address); end
   endtask

   task automatic test_ras();
      logic [31:0] exp_ret [4];
      exp_ret[0] = 32'h8000_0044; exp_ret[1] = 32'h8000_0034;
      exp_ret[2] = 32'h8000_0024; exp_ret[3] = 32'h8000_0014;
      do_flush(32'h8000_0000);
      for (int i = 0; i < 5; i++) begin
         tests_run++; if (inst_address !== 32'h8000_0000 + 32'(i * 16)) begin tests_failed++; $display("FAIL ras_call_pc%0d: got %h want %h", i, inst_address, 32'h8000_0000 + 32'(i * 16)); end
         jmp_valid = 1; jmp_addr = 32'h8000_0100; call = 1;
         tick(); idle();
         br_taken = 1; br_addr = 32'h8000_0000 + 32'((i + 1) * 16);
         tick(); idle();
      end
      tests_run++; if (ras_full !== 1'b1 || ras_empty !== 1'b0) begin tests_failed++; $display("FAIL ras_full: got full=%b empty=%b want 1 0", ras_full, ras_empty); end
      for (int i = 0; i < 4; i++) begin
         jr_valid = 1; ret = 1; jr_addr = 32'h8000_0200;
         tick(); idle();
         tests_run++; if (inst_address !== exp_ret[i]) begin tests_failed++; $display("FAIL ras_ret%0d: got %h want %h", i, inst_address, exp_ret[i]); end
         if (i == 0) begin
            tests_run++; if (ras_full !== 1'b0) begin tests_failed++; $display("FAIL ras_not_full: got %b want 0", ras_full); end
         end
      end
      tests_run++; if (ras_empty !== 1'b1) begin tests_failed++; $display("FAIL ras_drained: got empty=%b want 1", ras_empty); end
      jr_valid = 1; ret = 1; jr_addr = 32'h8000_0200;
      tick(); idle();
      tests_run++; if (inst_address !== 32'h8000_0200 || ras_empty !== 1'b1) begin tests_failed++; $display("FAIL ras_ret_empty: got pc=%h empty=%b want 80000200 1", inst_address, ras_empty); end
   endtask

   task automatic test_misalign();
      do_flush(32'h8000_0000);
      br_taken = 1; br_addr = 32'h8000_0006;
      tick(); idle();
      tests_run++; if (inst_address !== 32'h8000_0004 || misalign !== 1'b1) begin tests_failed++; $display("FAIL misalign_hit: got pc=%h mis=%b want 80000004 1", inst_address, misalign); end
      tick();
      tests_run++; if (inst_address !== 32'h8000_0008 || misalign !== 1'b0) begin tests_failed++; $display("FAIL misalign_pulse: got pc=%h mis=%b want 80000008 0", inst_address, misalign); end
   endtask

   task automatic test_call_ret();
      do_flush(32'h8000_004C);
      jmp_valid = 1; jmp_addr = 32'h8000_0060; call = 1;
      tick(); idle();
      tests_run++; if (inst_address !== 32'h8000_0060 || ras_empty !== 1'b0) begin tests_failed++; $display("FAIL cr_setup: got pc=%h empty=%b want 80000060 0", inst_address, ras_empty); end
      jr_valid = 1; jr_addr = 32'h8000_0300; call = 1; ret = 1;
      tick(); idle();
      tests_run++; if (inst_address !== 32'h8000_0050 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin tests_failed++; $display("FAIL cr_swap: got pc=%h empty=%b full=%b want 80000050 0 0", inst_address, ras_empty, ras_full); end
      jr_valid = 1; jr_addr = 32'h8000_0300; ret = 1;
      tick(); idle();
      tests_run++; if (inst_address !== 32'h8000_0064 || ras_empty !== 1'b1) begin tests_failed++; $display("FAIL cr_top: got pc=%h empty=%b want 80000064 1", inst_address, ras_empty); end
   endtask

   task automatic test_wrap();
      do_flush(32'hFFFF_FFF8);
      tick();
      tests_run++; if (inst_address !== 32'hFFFF_FFFC || next_instaddress !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap_pre: got pc=%h next=%h want fffffffc 00000000", inst_address, next_instaddress); end
      tick();
      tests_run++; if (inst_address !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap: got %h want 00000000", inst_address); end
   endtask

   task automatic test_async_reset();
      jmp_valid = 1; jmp_addr = 32'h8000_0700; call = 1;
      tick();
      tests_run++; if (inst_address !== 32'h8000_0700 || ras_empty !== 1'b0) begin tests_failed++; $display("FAIL areset_setup: got pc=%h empty=%b want 80000700 0", inst_address, ras_empty); end
      #2 rst = 1;
      #1;
      tests_run++; if (inst_address !== 32'h8000_0000 || ce !== 1'b0 || ras_empty !== 1'b1 || misalign !== 1'b0) begin tests_failed++; $display("FAIL areset: got pc=%h ce=%b empty=%b mis=%b want 80000000 0 1 0", inst_address, ce, ras_empty, misalign); end
      @(negedge clk);
      tests_run++; if (inst_address !== 32'h8000_0000 || ce !== 1'b0) begin tests_failed++; $display("FAIL areset_hold: got pc=%h ce=%b want 80000000 0", inst_address, ce); end
      idle();
   endtask

   initial begin
      test_reset();
      test_priority();
      test_ras();
      test_misalign();
      test_call_ret();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
